// File: rtl/axis_test_pkg.sv
// Shared state encoding and default widths for the AXI-stream loopback tester.
package axis_test_pkg;

  localparam int DEF_DATA_WIDTH     = 32;
  localparam int DEF_CNT_W          = 16;
  localparam int DEF_TIMEOUT_CYCLES = 1024;

  // Reported as first_err_idx while no mismatch has been seen.
  localparam logic [DEF_CNT_W-1:0] NO_ERR = '1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/axis_seq_gen.sv
// Sequence source: word k = seed + k, one register step per advance; 0-cycle output from registers.
// clear reloads the seed and zeroes the index; no backpressure of its own.
module axis_seq_gen #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] seed,
  input  logic                  advance,
  output logic [CNT_W-1:0]      idx,
  output logic [DATA_WIDTH-1:0] word
);

  // The running word is kept directly so no adder sits on the output path.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx  <= '0;
      word <= '0;
    end else if (clear) begin
      idx  <= '0;
      word <= seed;
    end else if (advance) begin
      idx  <= idx + CNT_W'(1);
      word <= word + DATA_WIDTH'(1);
    end
  end

endmodule

// File: rtl/axis_loopback_tester.sv
// Drives seed+k words out of the master port and checks the looped-back stream on the slave port.
// Master honours m_axis_ready (data held while stalled); slave is always ready while busy, results 1 cycle after each beat.
module axis_loopback_tester
  import axis_test_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int CNT_W          = DEF_CNT_W,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                  axi_clk,
  input  logic                  axi_reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] seed,
  input  logic [CNT_W-1:0]      num_words,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic                  timeout,
  output logic [CNT_W-1:0]      err_count,
  output logic [CNT_W-1:0]      first_err_idx,
  output logic [CNT_W-1:0]      tx_count,
  output logic [CNT_W-1:0]      rx_count,
  output logic                  m_axis_valid,
  output logic [DATA_WIDTH-1:0] m_axis_data,
  input  logic                  m_axis_ready,
  input  logic                  s_axis_valid,
  input  logic [DATA_WIDTH-1:0] s_axis_data,
  output logic                  s_axis_ready
);

  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] NO_ERR_IDX = {CNT_W{NO_ERR[0]}};

  state_t             state;
  logic [CNT_W-1:0]   num_q;
  logic [IDLE_W-1:0]  idle_cnt;
  logic [DATA_WIDTH-1:0] rx_word;

  logic start_ok;
  logic tx_hs;
  logic tx_last;
  logic rx_hs;
  logic rx_last;
  logic rx_bad;

  assign start_ok = start & ((state == ST_IDLE) | (state == ST_DONE));
  assign tx_hs    = m_axis_valid & m_axis_ready;
  assign tx_last  = tx_hs & (tx_count == num_q - CNT_W'(1));
  // Beats past num_words are not counted even though ready stays high until DONE.
  assign rx_hs    = s_axis_valid & s_axis_ready & (rx_count != num_q);
  assign rx_last  = rx_hs & (rx_count == num_q - CNT_W'(1));
  assign rx_bad   = rx_hs & (s_axis_data != rx_word);

  axis_seq_gen #(
    .DATA_WIDTH (DATA_WIDTH),
    .CNT_W      (CNT_W)
  ) u_tx_gen (
    .clk     (axi_clk),
    .reset   (axi_reset),
    .clear   (start_ok),
    .seed    (seed),
    .advance (tx_hs),
    .idx     (tx_count),
    .word    (m_axis_data)
  );

  axis_seq_gen #(
    .DATA_WIDTH (DATA_WIDTH),
    .CNT_W      (CNT_W)
  ) u_rx_gen (
    .clk     (axi_clk),
    .reset   (axi_reset),
    .clear   (start_ok),
    .seed    (seed),
    .advance (rx_hs),
    .idx     (rx_count),
    .word    (rx_word)
  );

  always_ff @(posedge axi_clk) begin
    if (axi_reset) begin
      state         <= ST_IDLE;
      num_q         <= '0;
      idle_cnt      <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      timeout       <= 1'b0;
      err_count     <= '0;
      first_err_idx <= NO_ERR_IDX;
      m_axis_valid  <= 1'b0;
      s_axis_ready  <= 1'b0;
    end else begin
      if (rx_bad) begin
        if (err_count != '1)
          err_count <= err_count + CNT_W'(1);
        if (err_count == '0)
          first_err_idx <= rx_count;
      end

      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            num_q         <= num_words;
            idle_cnt      <= '0;
            err_count     <= '0;
            first_err_idx <= NO_ERR_IDX;
            timeout       <= 1'b0;
            if (num_words == '0) begin
              state <= ST_DONE;
              done  <= 1'b1;
              pass  <= 1'b1;
            end else begin
              state        <= ST_RUN;
              busy         <= 1'b1;
              done         <= 1'b0;
              pass         <= 1'b0;
              m_axis_valid <= 1'b1;
              s_axis_ready <= 1'b1;
            end
          end
        end

        ST_RUN: begin
          if (tx_last) begin
            state        <= ST_DRAIN;
            m_axis_valid <= 1'b0;
            // The hand-off cycle already counts as idle if nothing came back in it.
            idle_cnt     <= rx_hs ? '0 : IDLE_W'(1);
          end
        end

        ST_DRAIN: begin
          if ((rx_count == num_q) || rx_last) begin
            state        <= ST_DONE;
            busy         <= 1'b0;
            done         <= 1'b1;
            s_axis_ready <= 1'b0;
            pass         <= (err_count == '0) & ~rx_bad;
          end else if (rx_hs) begin
            idle_cnt <= '0;
          end else if (idle_cnt == IDLE_W'(TIMEOUT_CYCLES - 1)) begin
            state        <= ST_DONE;
            busy         <= 1'b0;
            done         <= 1'b1;
            s_axis_ready <= 1'b0;
            timeout      <= 1'b1;
            pass         <= 1'b0;
          end else begin
            idle_cnt <= idle_cnt + IDLE_W'(1);
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/axis_loopback_tester.md
Name: axis_loopback_tester

Overview:
AXI-stream traffic generator and checker that drives the stream loopback from the opposite end. The master port sources a deterministic word sequence into the loopback's slave port. The slave port consumes the looped-back words and compares each one against an independently regenerated expected sequence. Results go to a small status interface for a processor or VIO.

Parameters:
DATA_WIDTH, 32, stream word width in bits; a multiple of 8.
CNT_W, 16, width of word-count and error-count fields.
TIMEOUT_CYCLES, 1024, idle cycles allowed in DRAIN before the run is declared failed.

Ports:
axi_clk  in  1  single clock for all logic.
axi_reset  in  1  synchronous, active-high reset.
start  in  1  one-cycle pulse; begins a run; honoured only in IDLE or DONE.
seed  in  DATA_WIDTH  first word of the sequence; sampled on start.
num_words  in  CNT_W  words per run; sampled on start; 0 means finish immediately.
busy  out  1  high in RUN and DRAIN.
done  out  1  high in DONE; stays high until the next start or reset.
pass  out  1  valid when done: 1 iff err_count==0 and no timeout.
timeout  out  1  set when DRAIN times out.
err_count  out  CNT_W  number of mismatched received words; saturates at all-ones.
first_err_idx  out  CNT_W  index of the first mismatch; all-ones if none.
tx_count  out  CNT_W  words accepted on the master port.
rx_count  out  CNT_W  words accepted on the slave port.
m_axis_valid  out  1  master valid.
m_axis_data  out  DATA_WIDTH  master data.
m_axis_ready  in  1  master ready.
s_axis_valid  in  1  slave valid.
s_axis_data  in  DATA_WIDTH  slave data.
s_axis_ready  out  1  slave ready.

Behaviour:
- Reset: the FSM goes to IDLE, and every output is driven to 0 except first_err_idx, which is driven to all-ones. This includes m_axis_valid, m_axis_data, s_axis_ready, done, pass and timeout. Reset mid-run aborts immediately and does not wait for handshakes.
- Sequence: word k = seed + k, modulo 2^DATA_WIDTH, so it wraps past all-ones to 0. The tx and rx sides each keep their own index register.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE or DONE, on start:
  - latch seed and num_words;
  - clear all counters, err_count, timeout and done;
  - set first_err_idx to all-ones;
  - go to RUN, or straight to DONE with pass=1 if num_words==0.
- start while busy is ignored.
- RUN, tx side:
  - m_axis_valid goes high the cycle after entry, with m_axis_data = seed.
  - On a handshake (valid & ready), tx_count and the tx index increment and the next word is presented in the following cycle without deasserting valid.
  - After the handshake of word num_words-1, m_axis_valid drops the next cycle.
  - Valid and data never change while valid=1 and ready=0.
- RUN and DRAIN, rx side:
  - s_axis_ready is held at 1.
  - On each handshake, s_axis_data is compared with seed + rx_count; rx_count then increments.
  - On a mismatch, err_count increments (saturating). On the first mismatch, first_err_idx takes the current rx_count.
  - Compare and count update take effect 1 cycle after the handshake.
- Transmit and receive beats in the same cycle are both processed.
- RUN -> DRAIN when tx_count reaches num_words.
- DRAIN:
  - An idle counter resets on every rx beat and increments otherwise.
  - rx_count == num_words -> DONE.
  - Idle counter reaching TIMEOUT_CYCLES -> timeout=1, DONE.
- If rx_count reaches num_words while still in RUN, rx beats stop being counted. s_axis_ready drops only at DONE.
- Extra rx beats arriving in DONE are not accepted (s_axis_ready=0).
- DONE: pass = (err_count==0) & ~timeout, registered on entry; s_axis_ready=0, m_axis_valid=0.

Decomposition:
- Shared package axis_test_pkg holds:
  - the FSM state enum (IDLE, RUN, DRAIN, DONE);
  - the default widths;
  - the all-ones NO_ERR index constant.
- One natural sub-module, axis_seq_gen: seed register plus an index counter with advance/clear inputs, outputting the current word. It is instantiated twice, once for tx and once for rx-expected.

Test Plan:
- Direct loopback with ready=1, seed=0x00000010, num_words=8 -> tx sends 0x10..0x17 on 8 consecutive cycles; done; pass=1; rx_count=8; err_count=0.
- Random m_axis_ready backpressure (50%), num_words=100 -> m_axis_data stable whenever valid&~ready; pass=1; tx_count=rx_count=100.
- Bit 0 of word 5 corrupted in the loopback path, seed=0 -> err_count=1, first_err_idx=5, pass=0.
- seed=0xFFFFFFFE, num_words=4 -> words FFFFFFFE, FFFFFFFF, 00000000, 00000001; pass=1.
- Loopback drops its last word -> timeout=1 exactly TIMEOUT_CYCLES cycles after the last rx beat; rx_count=num_words-1; pass=0.
- axi_reset asserted mid-RUN at word 3 -> next cycle: IDLE, m_axis_valid=0, counters 0. A start with num_words=0 then gives done=1, pass=1 with no beats.
